// File: rtl/product_bcd_converter_if.sv
// Handshake and result bundle between the multiplier-side controller and the
// product BCD converter.
interface product_bcd_converter_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
);
   logic                  Start;
   logic [WIDTH-1:0]      Product;
   logic                  Busy;
   logic                  Done;
   logic                  Negative;
   logic [4*DIGITS-1:0]   Bcd;

   modport master (
      output Start, Product,
      input  Busy, Done, Negative, Bcd
   );

   modport slave (
      input  Start, Product,
      output Busy, Done, Negative, Bcd
   );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble converter: signed product in, sign flag plus packed
// BCD magnitude out, one product bit consumed per ADJUST/SHIFT pair.
module product_bcd_converter #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DIGITS = 5
) (
   input  logic                      Clk,
   input  logic                      Reset,
   product_bcd_converter_if.slave    bus
);
   localparam int unsigned SW = 4 * DIGITS;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   function automatic longint unsigned pow_u(input int unsigned base, input int unsigned ex);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < ex; i++) r = r * 64'(base);
      return r;
   endfunction

   generate
      if (pow_u(10, DIGITS) <= pow_u(2, WIDTH - 1)) begin : g_digits_too_few
         $error("DIGITS too small to hold the largest magnitude of a WIDTH-bit product");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, ADJUST, SHIFT, DONE} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  mag_q, mag_d;
   logic [SW-1:0]     scratch_q, scratch_d;
   logic [CW-1:0]     count_q, count_d;
   logic              sign_q, sign_d;
   logic [SW-1:0]     bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d   = state_q;
      mag_d     = mag_q;
      scratch_d = scratch_q;
      count_d   = count_q;
      sign_d    = sign_q;
      bcd_d     = bcd_q;
      neg_d     = neg_q;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               // Unsigned negate: the most negative product maps onto itself, which is its true magnitude.
               mag_d     = bus.Product[WIDTH-1] ? (~bus.Product + WIDTH'(1)) : bus.Product;
               sign_d    = bus.Product[WIDTH-1];
               scratch_d = '0;
               count_d   = '0;
               state_d   = ADJUST;
            end
         end
         ADJUST: begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (scratch_q[4*i +: 4] >= 4'd5) scratch_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
            state_d = SHIFT;
         end
         SHIFT: begin
            {scratch_d, mag_d} = {scratch_q[SW-2:0], mag_q, 1'b0};
            count_d            = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
               bcd_d   = {scratch_q[SW-2:0], mag_q[WIDTH-1]};
               neg_d   = sign_q;
               state_d = DONE;
            end else begin
               state_d = ADJUST;
            end
         end
         default: state_d = IDLE;
      endcase
      // Status flags are registered copies of the next state so they stay Moore-aligned.
      busy_d = (state_d == ADJUST) || (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         mag_q     <= '0;
         scratch_q <= '0;
         count_q   <= '0;
         sign_q    <= 1'b0;
         bcd_q     <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mag_q     <= mag_d;
         scratch_q <= scratch_d;
         count_q   <= count_d;
         sign_q    <= sign_d;
         bcd_q     <= bcd_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.Busy     = busy_q;
   assign bus.Done     = done_q;
   assign bus.Negative = neg_q;
   assign bus.Bcd      = bcd_q;
endmodule
